uart_tx_datapath: RTL and testbench

//  UART transmit datapath that sits directly downstream of the UART TX control FSM.
//  - Captures the parallel byte and computes its parity bit.
//  - Serializes the byte LSB-first under the FSM's ser_en, and returns ser_done.
//  - Selects the line bit from the FSM's mux_sel into a registered TX_OUT.
//  - TX_OUT is registered so it stays cycle-aligned with the FSM's registered busy.

---
 rtl/uart_tx_datapath_if.sv | 22 ++
 rtl/uart_tx_datapath.sv | 84 ++++++++
 tb/tb_uart_tx_datapath.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_datapath_if.sv
// Signal bundle between the UART TX control FSM side and the TX datapath.
interface uart_tx_datapath_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_TYP;
  logic                  ser_en;
  logic [2:0]            mux_sel;
  logic                  ser_done;
  logic                  TX_OUT;

  modport master (
    output P_DATA, Data_Valid, PAR_TYP, ser_en, mux_sel,
    input  ser_done, TX_OUT
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_TYP, ser_en, mux_sel,
    output ser_done, TX_OUT
  );
endinterface

// File: rtl/uart_tx_datapath.sv
// UART TX datapath: byte capture, parity, LSB-first serializer and registered line mux.
module uart_tx_datapath #(
  parameter int DATA_WIDTH = 8
) (
  input logic               CLK,
  input logic               RST,
  uart_tx_datapath_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    SEL_IDLE  = 3'b000,
    SEL_STOP  = 3'b001,
    SEL_DATA  = 3'b010,
    SEL_PAR   = 3'b011,
    SEL_START = 3'b111
  } sel_e;

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  data_par_q;
  logic                  par_typ_q;
  logic                  par_bit;
  logic                  load;
  logic                  sel_bit;
  logic                  tx_q;

  assign load = bus.Data_Valid && (bus.mux_sel == SEL_IDLE) && !bus.ser_en;

  // Data parity and parity type are latched separately; their XOR equals ^P_DATA ^ PAR_TYP.
  assign par_bit = data_par_q ^ par_typ_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shift_reg  <= '0;
      data_par_q <= 1'b0;
      par_typ_q  <= 1'b0;
    end else if (load) begin
      shift_reg  <= bus.P_DATA;
      data_par_q <= ^bus.P_DATA;
      par_typ_q  <= bus.PAR_TYP;
    end else if (bus.ser_en) begin
      shift_reg  <= shift_reg >> 1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bit_cnt <= '0;
    end else if (bus.ser_en && (bit_cnt != CNT_LAST)) begin
      bit_cnt <= bit_cnt + 1'b1;
    end else begin
      bit_cnt <= '0;
    end
  end

  assign bus.ser_done = (bit_cnt == CNT_LAST);

  always_comb begin
    sel_bit = 1'b1;
    case (bus.mux_sel)
      SEL_IDLE:  sel_bit = 1'b1;
      SEL_START: sel_bit = 1'b0;
      SEL_DATA:  sel_bit = shift_reg[0];
      SEL_PAR:   sel_bit = par_bit;
      SEL_STOP:  sel_bit = 1'b1;
      default:   sel_bit = 1'b1;
    endcase
  end

  // Registered so the line stays aligned with the FSM's registered busy.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_q <= 1'b1;
    end else begin
      tx_q <= sel_bit;
    end
  end

  assign bus.TX_OUT = tx_q;

endmodule

// File: tb/tb_uart_tx_datapath.sv
// Scoreboard bench for uart_tx_datapath with a small model of the TX control FSM.
module tb_uart_tx_datapath;

  localparam int DW = 8;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic par_en = 1'b0;
  int   cyc = 0;

  uart_tx_datapath_if #(.DATA_WIDTH(DW)) ifc ();

  uart_tx_datapath #(.DATA_WIDTH(DW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (ifc.slave)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef enum logic [2:0] {
    F_IDLE  = 3'b000,
    F_STOP  = 3'b001,
    F_DATA  = 3'b010,
    F_PAR   = 3'b011,
    F_START = 3'b111
  } fsm_e;

  fsm_e fsm_state;
  logic pen_q;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fsm_state <= F_IDLE;
      pen_q     <= 1'b0;
    end else begin
      case (fsm_state)
        F_IDLE:  if (ifc.Data_Valid) begin fsm_state <= F_START; pen_q <= par_en; end
        F_START: fsm_state <= F_DATA;
        F_DATA:  if (ifc.ser_done) fsm_state <= pen_q ? F_PAR : F_STOP;
        F_PAR:   fsm_state <= F_STOP;
        default: fsm_state <= F_IDLE;
      endcase
    end
  end

  assign ifc.mux_sel = fsm_state;
  assign ifc.ser_en  = (fsm_state == F_DATA) && !ifc.ser_done;

  typedef struct {
    logic [DW-1:0] data;
    logic          par;
    logic          pen;
    int            start;
    bit            gap;
  } frame_t;

  frame_t sb[$];
  frame_t cur;
  int  n_vec = 0;
  int  n_err = 0;
  bit  active = 0;
  int  idx = 0;
  int  sd_cnt = 0;
  int  last_stop = 0;
  int  last_load = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: follows TX_OUT and checks each frame popped from the scoreboard.
  initial begin
    forever begin
      @(negedge CLK);
      if (!RST) begin
        active = 0;
        sb.delete();
        sd_cnt = 0;
        continue;
      end
      if (ifc.ser_done === 1'b1) sd_cnt++;
      if (!active) begin
        if (ifc.TX_OUT !== 1'b1) begin
          chk("spurious_start", 32'(sb.size() > 0), 32'd1);
          if (sb.size() > 0) begin
            cur = sb.pop_front();
            chk("start_bit", 32'(ifc.TX_OUT), 32'd0);
            chk("start_cycle", 32'(cyc), 32'(cur.start));
            if (cur.gap) chk("idle_gap", 32'(cyc - last_stop - 1), 32'd1);
            active = 1;
            idx = 1;
            sd_cnt = 0;
          end
        end
      end else begin
        if (idx <= DW) begin
          chk($sformatf("data_bit%0d", idx - 1), 32'(ifc.TX_OUT), 32'(cur.data[idx-1]));
        end else if (cur.pen && idx == DW + 1) begin
          chk("parity_bit", 32'(ifc.TX_OUT), 32'(cur.par));
        end else begin
          chk("stop_bit", 32'(ifc.TX_OUT), 32'd1);
          chk("ser_done_once", 32'(sd_cnt), 32'd1);
          last_stop = cyc;
          active = 0;
        end
        idx++;
      end
    end
  end

  task automatic wait_fsm_idle();
    int n = 0;
    while (fsm_state != F_IDLE && n < 100) begin
      @(posedge CLK); #1; n++;
    end
    if (n >= 100) chk("fsm_idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic ptyp, input logic pen,
                      input logic exp_par);
    frame_t f;
    wait_fsm_idle();
    ifc.P_DATA     = d;
    ifc.PAR_TYP    = ptyp;
    par_en         = pen;
    ifc.Data_Valid = 1'b1;
    last_load      = cyc;
    f.data = d; f.par = exp_par; f.pen = pen; f.start = cyc + 2; f.gap = 0;
    sb.push_back(f);
    @(posedge CLK); #1;
    ifc.Data_Valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || active) && n < 200) begin
      @(posedge CLK); #1; n++;
    end
    chk("frame_timeout", 32'(n < 200), 32'd1);
    repeat (2) @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
    $fatal(1);
  end

  initial begin
    frame_t f;
    ifc.P_DATA     = '0;
    ifc.PAR_TYP    = 1'b0;
    ifc.Data_Valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_tx_out", 32'(ifc.TX_OUT), 32'd1);
    chk("reset_ser_done", 32'(ifc.ser_done), 32'd0);
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    // A5 even parity / odd parity, 00 odd parity
    send(8'hA5, 1'b0, 1'b1, 1'b0);
    wait_done();
    send(8'hA5, 1'b1, 1'b1, 1'b1);
    wait_done();
    send(8'h00, 1'b1, 1'b1, 1'b1);
    wait_done();

    // no parity, all ones
    send(8'hFF, 1'b0, 1'b0, 1'b0);
    wait_done();

    // mid-frame change of P_DATA / PAR_TYP with a Data_Valid pulse must be ignored
    send(8'hA5, 1'b0, 1'b1, 1'b0);
    repeat (4) @(posedge CLK);
    #1;
    ifc.P_DATA     = 8'h3C;
    ifc.PAR_TYP    = 1'b1;
    ifc.Data_Valid = 1'b1;
    @(posedge CLK); #1;
    ifc.Data_Valid = 1'b0;
    wait_done();

    // reset while data bit 4 is on the line
    send(8'hA5, 1'b0, 1'b1, 1'b0);
    while (cyc < last_load + 7) begin
      @(posedge CLK); #1;
    end
    chk("pre_reset_bit4", 32'(ifc.TX_OUT), 32'd0);
    #2 RST = 1'b0;
    #1;
    chk("abort_tx_out", 32'(ifc.TX_OUT), 32'd1);
    chk("abort_bit_cnt", 32'(dut.bit_cnt), 32'd0);
    chk("abort_ser_done", 32'(ifc.ser_done), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    send(8'h3C, 1'b0, 1'b1, 1'b0);
    wait_done();

    // back-to-back with Data_Valid held high: 81 (even) then 7E (odd)
    wait_fsm_idle();
    ifc.P_DATA     = 8'h81;
    ifc.PAR_TYP    = 1'b0;
    par_en         = 1'b1;
    ifc.Data_Valid = 1'b1;
    last_load      = cyc;
    f.data = 8'h81; f.par = 1'b0; f.pen = 1'b1; f.start = cyc + 2; f.gap = 0;
    sb.push_back(f);
    f.data = 8'h7E; f.par = 1'b1; f.pen = 1'b1; f.start = cyc + DW + 4 + 2; f.gap = 1;
    sb.push_back(f);
    @(posedge CLK); #1;
    ifc.P_DATA  = 8'h7E;
    ifc.PAR_TYP = 1'b1;
    while (cyc < last_load + DW + 4) begin
      @(posedge CLK); #1;
    end
    @(posedge CLK); #1;
    ifc.Data_Valid = 1'b0;
    wait_done();

    repeat (5) @(posedge CLK);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    chk("final_idle_line", 32'(ifc.TX_OUT), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
